// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon button front end.
package simon_pkg;

  localparam int NUM_BTN = 4;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

endpackage

// File: rtl/debounce_bit.sv
// One button bit: multi-flop synchroniser followed by a stable-run debounce counter.
module debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
    cnt_d   = '0;
    level_d = level_q;
    // A bounce back to the current level falls into the default and restarts the run.
    if (sync_bit != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_bit;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the raw buttons and turns clean single presses into one-hot pulses,
// rejecting chorded or overlapping presses with a multi_press flag.
module button_conditioner #(
  parameter int NUM_BTN         = simon_pkg::NUM_BTN,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               multi_press,
  output logic               busy
);

  import simon_pkg::*;

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] held_q, held_d;
  logic [NUM_BTN-1:0] pulse_q, pulse_d;
  logic               multi_q, multi_d;
  logic               busy_q;
  state_t             state_q, state_d;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[g]),
      .level(level[g])
    );
  end

  assign rise = level & ~level_q;

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    pulse_d = '0;
    multi_d = 1'b0;
    case (state_q)
      IDLE: begin
        // In IDLE every down bit is a fresh rise, so extra level bits mean a chord.
        if (($countones(rise) == 1) && (level == rise)) begin
          pulse_d = rise;
          held_d  = rise;
          state_d = HELD;
        end else if ((rise != '0) || (level != '0)) begin
          multi_d = 1'b1;
          state_d = LOCKOUT;
        end
      end
      HELD: begin
        if ((rise & ~held_q) != '0) begin
          multi_d = 1'b1;
          state_d = LOCKOUT;
        end else if (level == '0) begin
          state_d = IDLE;
        end
      end
      LOCKOUT: begin
        if (level == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      held_q  <= '0;
      level_q <= '0;
      pulse_q <= '0;
      multi_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      level_q <= level;
      pulse_q <= pulse_d;
      multi_q <= multi_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign btn_level   = level;
  assign btn_pulse   = pulse_q;
  assign multi_press = multi_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized checks of button_conditioner against a cycle reference model.
module tb_button_conditioner;

  localparam int NB   = 4;
  localparam int DEB  = 4;
  localparam int SYNC = 2;

  logic          clk;
  logic          reset;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic          multi_press;
  logic          busy;

  button_conditioner #(
    .NUM_BTN        (NB),
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .multi_press(multi_press),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pulse_seen = 0;
  int multi_seen = 0;

  // Reference model state: raw delayed through the synchroniser, recent synced samples,
  // accepted levels, and who (if anyone) owns the current press.
  logic [NB-1:0] pipe [SYNC];
  logic [NB-1:0] hist [$];
  logic [NB-1:0] m_level, m_prev, m_pulse;
  logic          m_multi;
  int            holder;
  bit            locked;

  task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [NB-1:0] r, input logic rs);
    logic [NB-1:0] rise, s, nl;
    bit all_same;
    if (rs) begin
      for (int k = 0; k < SYNC; k++) pipe[k] = '0;
      hist.delete();
      m_level = '0; m_prev = '0; m_pulse = '0; m_multi = 1'b0;
      holder = -1; locked = 1'b0;
    end else begin
      rise    = m_level & ~m_prev;
      m_pulse = '0;
      m_multi = 1'b0;
      if (locked) begin
        if (m_level == '0) locked = 1'b0;
      end else if (holder >= 0) begin
        if ((rise & ~(4'b0001 << holder)) != '0) begin
          m_multi = 1'b1; locked = 1'b1; holder = -1;
        end else if (m_level == '0) begin
          holder = -1;
        end
      end else begin
        if (($countones(rise) == 1) && (m_level == rise)) begin
          m_pulse = rise;
          for (int b = 0; b < NB; b++) if (rise[b]) holder = b;
        end else if (m_level != '0) begin
          m_multi = 1'b1; locked = 1'b1;
        end
      end
      m_prev = m_level;
      // A level is accepted once the last DEB synchronised samples all disagree with it.
      s = pipe[SYNC-1];
      hist.push_back(s);
      if (hist.size() > DEB) void'(hist.pop_front());
      nl = m_level;
      if (hist.size() == DEB) begin
        for (int b = 0; b < NB; b++) begin
          all_same = 1'b1;
          for (int k = 0; k < DEB; k++) if (hist[k][b] != s[b]) all_same = 1'b0;
          if (all_same && (s[b] != m_level[b])) nl[b] = s[b];
        end
      end
      m_level = nl;
      for (int k = SYNC - 1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = r;
    end
  endtask

  task automatic step(input logic [NB-1:0] r, input logic rs);
    btn_raw = r;
    reset   = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
    chk("level", btn_level, m_level);
    chk("pulse", btn_pulse, m_pulse);
    chk("multi", {3'b000, multi_press}, {3'b000, m_multi});
    chk("busy",  {3'b000, busy}, {3'b000, (locked || holder >= 0)});
    chk("pulse_excl", {3'b000, (btn_pulse != '0) && multi_press}, 4'b0000);
    if (btn_pulse != '0) pulse_seen++;
    if (multi_press) multi_seen++;
  endtask

  task automatic hold(input logic [NB-1:0] r, input int n);
    for (int i = 0; i < n; i++) step(r, 1'b0);
  endtask

  int p0, m0;
  logic [NB-1:0] rv;
  int rlen;

  initial begin
    btn_raw = '0;
    reset   = 1'b1;
    for (int k = 0; k < SYNC; k++) pipe[k] = '0;
    m_level = '0; m_prev = '0; m_pulse = '0; m_multi = 1'b0;
    holder = -1; locked = 1'b0;

    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("rst_level", btn_level, 4'b0000);
    chk("rst_pulse", btn_pulse, 4'b0000);
    chk("rst_flags", {2'b00, multi_press, busy}, 4'b0000);

    // Single press: level after edge 6, pulse only after edge 7.
    for (int i = 1; i <= 10; i++) begin
      step(4'b0010, 1'b0);
      if (i == 5) chk("t1_level_e5", btn_level, 4'b0000);
      if (i == 6) chk("t1_level_e6", btn_level, 4'b0010);
      if (i == 6) chk("t1_pulse_e6", btn_pulse, 4'b0000);
      if (i == 7) chk("t1_pulse_e7", btn_pulse, 4'b0010);
      if (i == 8) chk("t1_pulse_e8", btn_pulse, 4'b0000);
      if (i == 8) chk("t1_busy", {3'b000, busy}, 4'b0001);
    end
    hold(4'b0000, 10);
    chk("t1_idle", {3'b000, busy}, 4'b0000);

    // Bounce never settles long enough.
    p0 = pulse_seen; m0 = multi_seen;
    for (int i = 0; i < 20; i++) step(((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0);
    hold(4'b0000, 10);
    chk("t2_pulses", 4'(pulse_seen - p0), 4'd0);
    chk("t2_multi", 4'(multi_seen - m0), 4'd0);

    // Chord.
    p0 = pulse_seen; m0 = multi_seen;
    hold(4'b0101, 10);
    chk("t3_busy", {3'b000, busy}, 4'b0001);
    hold(4'b0000, 10);
    chk("t3_pulses", 4'(pulse_seen - p0), 4'd0);
    chk("t3_multi", 4'(multi_seen - m0), 4'd1);
    chk("t3_idle", {3'b000, busy}, 4'b0000);

    // Overlap, then a clean press of the second button.
    p0 = pulse_seen; m0 = multi_seen;
    hold(4'b1000, 10);
    hold(4'b1001, 10);
    hold(4'b0000, 10);
    chk("t4_multi", 4'(multi_seen - m0), 4'd1);
    p0 = pulse_seen;
    hold(4'b0001, 10);
    hold(4'b0000, 10);
    chk("t4_pulses", 4'(pulse_seen - p0), 4'd1);

    // Repeated presses.
    p0 = pulse_seen; m0 = multi_seen;
    for (int i = 0; i < 3; i++) begin
      hold(4'b0100, 10);
      hold(4'b0000, 10);
    end
    chk("t5_pulses", 4'(pulse_seen - p0), 4'd3);
    chk("t5_multi", 4'(multi_seen - m0), 4'd0);

    // Reset while held, button still down afterwards.
    hold(4'b0010, 10);
    chk("t6_busy_pre", {3'b000, busy}, 4'b0001);
    step(4'b0010, 1'b1);
    chk("t6_rst_level", btn_level, 4'b0000);
    chk("t6_rst_flags", {2'b00, multi_press, busy}, 4'b0000);
    for (int i = 1; i <= 8; i++) begin
      step(4'b0010, 1'b0);
      if (i == 6) chk("t6_pulse_e6", btn_pulse, 4'b0000);
      if (i == 7) chk("t6_pulse_e7", btn_pulse, 4'b0010);
      if (i == 8) chk("t6_pulse_e8", btn_pulse, 4'b0000);
    end
    hold(4'b0000, 10);

    // Random presses, chords, bounces and occasional resets.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) rv = 4'($urandom_range(0, 15));
      else rv = 4'b0001 << $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) rv = '0;
      rlen = $urandom_range(1, 14);
      for (int k = 0; k < rlen; k++) step(rv, ($urandom_range(0, 299) == 0));
    end
    hold(4'b0000, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
